// File: rtl/dmem_responder.sv
// RV64 data-memory responder: one outstanding load/store against a DEPTH x 64-bit array, response after LATENCY cycles.
// Optional macro DMEM_BACK_TO_BACK_EN lets the response handshake edge also accept the next request.
module dmem_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    input  logic [5:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic [5:0]  resp_rd,
    output logic        resp_load,
    output logic        resp_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit LAT1 = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [63:0]     mem [DEPTH];

    logic            cap_load;
    logic [IW+2:0]   cap_addr;
    logic [1:0]      cap_size;
    logic            cap_unsigned;
    logic [63:0]     cap_wdata;
    logic [5:0]      cap_rd;

    logic            accept;
    logic            do_access;
    logic            a_load;
    logic [IW+2:0]   a_addr;
    logic [1:0]      a_size;
    logic            a_unsigned;
    logic [63:0]     a_wdata;
    logic [5:0]      a_rd;
    logic [2:0]      lane;
    logic [IW-1:0]   idx;
    logic            misalign;
    logic [63:0]     rd_word;
    logic [63:0]     shifted;
    logic [63:0]     ext;
    logic [63:0]     load_data;
    logic [7:0]      bmask;
    logic [63:0]     wmask;
    logic [63:0]     wr_word;

    // Upper address bits are deliberately ignored so the array wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[63:IW+3];

    assign accept = req_valid & req_ready;

    // With single-cycle latency the access happens on the accept edge itself.
    assign do_access = (state == BUSY && cnt == '0) || (LAT1 && accept);

    assign a_load     = LAT1 ? req_load              : cap_load;
    assign a_addr     = LAT1 ? req_addr[IW+2:0]      : cap_addr;
    assign a_size     = LAT1 ? req_size              : cap_size;
    assign a_unsigned = LAT1 ? req_unsigned          : cap_unsigned;
    assign a_wdata    = LAT1 ? req_wdata             : cap_wdata;
    assign a_rd       = LAT1 ? req_rd                : cap_rd;

    assign lane    = a_addr[2:0];
    assign idx     = a_addr[IW+2:3];
    assign rd_word = mem[idx];
    assign shifted = rd_word >> {lane, 3'b000};

    always_comb begin
        misalign = 1'b0;
        ext      = shifted;
        bmask    = 8'hFF;
        case (a_size)
            2'd0: begin
                ext   = a_unsigned ? {56'b0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
                bmask = 8'h01;
            end
            2'd1: begin
                misalign = lane[0];
                ext      = a_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
                bmask    = 8'h03;
            end
            2'd2: begin
                misalign = |lane[1:0];
                ext      = a_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
                bmask    = 8'h0F;
            end
            default: begin
                misalign = |lane;
                ext      = shifted;
                bmask    = 8'hFF;
            end
        endcase
    end

    assign load_data = (a_load && !misalign) ? ext : 64'd0;

    always_comb begin
        wmask = '0;
        for (int b = 0; b < 8; b++) begin
            wmask[b*8 +: 8] = {8{bmask[b]}};
        end
        wmask = wmask << {lane, 3'b000};
    end

    assign wr_word = (rd_word & ~wmask) | ((a_wdata << {lane, 3'b000}) & wmask);

    always_ff @(posedge clk) begin
        if (!reset && do_access && !a_load && !misalign) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cap_load     <= req_load;
            cap_addr     <= req_addr[IW+2:0];
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_wdata    <= req_wdata;
            cap_rd       <= req_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = LAT1 ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
`ifdef DMEM_BACK_TO_BACK_EN
                    if (req_valid) begin
                        state_nxt = LAT1 ? RESP : BUSY;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        resp_valid = (state == RESP);
`ifdef DMEM_BACK_TO_BACK_EN
        req_ready  = (state == IDLE) || (state == RESP && resp_ready);
`else
        req_ready  = (state == IDLE);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CW'(LATENCY - 1);
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_rd    <= '0;
            resp_load  <= 1'b0;
            resp_err   <= 1'b0;
        end else if (do_access) begin
            resp_rdata <= load_data;
            resp_rd    <= a_rd;
            resp_load  <= a_load;
            resp_err   <= misalign;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int LAT   = 2;
    localparam int DEPTH = 512;
    localparam int MB    = DEPTH * 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic [5:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic [5:0]  resp_rd;
    logic        resp_load;
    logic        resp_err;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_load(resp_load), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] rdata;
        logic [5:0]  rd;
        logic        load;
        logic        err;
    } resp_t;

    resp_t       exp_q[$];
    longint      acc_q[$];
    int          checks = 0;
    int          passed = 0;
    int          rr_mode = 0;
    logic [7:0]  mb [MB];

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: byte-addressed memory, wraps modulo the array size.
    task automatic model(input logic ld, input logic [63:0] a, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd, input logic [5:0] rd,
                         output resp_t r);
        int nb;
        int base;
        logic [63:0] v;
        nb   = 1 << sz;
        base = int'(a % 64'(MB));
        r.rd    = rd;
        r.load  = ld;
        r.err   = (a % 64'(nb)) != 0;
        r.rdata = '0;
        if (!r.err) begin
            if (ld) begin
                v = '0;
                for (int i = 0; i < nb; i++) v |= 64'(mb[base + i]) << (8 * i);
                if (!uns && nb < 8 && v[8 * nb - 1]) v |= ~((64'd1 << (8 * nb)) - 64'd1);
                r.rdata = v;
            end else begin
                for (int i = 0; i < nb; i++) mb[base + i] = wd[8 * i +: 8];
            end
        end
    endtask

    task automatic issue(input logic ld, input logic [63:0] a, input logic [1:0] sz,
                         input logic uns, input logic [63:0] wd, input logic [5:0] rd,
                         input bit track);
        resp_t r;
        bit done;
        done = 0;
        @(negedge clk);
        req_load = ld; req_addr = a; req_size = sz; req_unsigned = uns;
        req_wdata = wd; req_rd = rd; req_valid = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            #4;
            if (req_ready) begin
                @(posedge clk);
                done = 1;
                if (track) begin
                    model(ld, a, sz, uns, wd, rd, r);
                    exp_q.push_back(r);
                    acc_q.push_back(longint'($time));
                end
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        #1 req_valid = 1'b0;
        if (!done) check("req_accept_timeout", 80'd0, 80'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 80'(exp_q.size()), 80'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},  80'(req_ready),  80'd1);
        check({tag, "_resp_valid"}, 80'(resp_valid), 80'd0);
        check({tag, "_resp_rdata"}, 80'(resp_rdata), 80'd0);
        check({tag, "_resp_rd"},    80'(resp_rd),    80'd0);
        check({tag, "_resp_load"},  80'(resp_load),  80'd0);
        check({tag, "_resp_err"},   80'(resp_err),   80'd0);
    endtask

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       resp_ready = ($urandom_range(0, 9) < 7);
                1:       resp_ready = 1'b0;
                default: resp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: latency, hold stability under backpressure, and scoreboard compare.
    initial begin
        resp_t cur, held, e;
        bit hv, seen;
        hv = 0; seen = 0;
        forever begin
            @(negedge clk);
            if (!reset && resp_valid) begin
                cur = '{resp_rdata, resp_rd, resp_load, resp_err};
                if (!seen) begin
                    seen = 1;
                    if (acc_q.size() != 0)
                        check("latency", 80'(longint'($time) - 5), 80'(acc_q.pop_front() + LAT * 10));
                end
                if (hv) check("hold_stable", 80'(cur), 80'(held));
                if (resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 80'd1, 80'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rdata", 80'(cur.rdata), 80'(e.rdata));
                        check("rd",    80'(cur.rd),    80'(e.rd));
                        check("load",  80'(cur.load),  80'(e.load));
                        check("err",   80'(cur.err),   80'(e.err));
                    end
                    hv = 0; seen = 0;
                end else begin
                    hv = 1; held = cur;
                end
            end else begin
                hv = 0; seen = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a;
        logic [1:0]  sz;
        int          n;
        reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; req_rd = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Fill the whole array so later random loads read defined data.
        for (int i = 0; i < DEPTH; i++)
            issue(1'b0, {$urandom, $urandom} & ~64'(MB - 1) | 64'(i * 8), 2'd3, 1'b0,
                  {$urandom, $urandom}, 6'(i), 1'b1);
        drain();

        issue(0, 64'h40,  3, 0, 64'h1122334455667788, 6'd1, 1);
        issue(1, 64'h40,  3, 0, 64'h0,                6'd2, 1);
        issue(0, 64'h103, 0, 0, 64'h80,               6'd3, 1);
        issue(1, 64'h103, 0, 0, 64'h0,                6'd4, 1);
        issue(1, 64'h103, 0, 1, 64'h0,                6'd5, 1);
        issue(0, 64'h106, 1, 0, 64'h8001,             6'd6, 1);
        issue(1, 64'h106, 1, 0, 64'h0,                6'd7, 1);
        issue(0, 64'h200, 3, 0, 64'h0,                6'd8, 1);
        issue(0, 64'h204, 2, 0, 64'hDEADBEEF,         6'd9, 1);
        issue(1, 64'h200, 3, 0, 64'h0,                6'd10, 1);
        issue(1, 64'h42,  2, 0, 64'h0,                6'd11, 1);
        issue(0, 64'h44,  3, 0, 64'hFFFF,             6'd12, 1);
        issue(1, 64'h40,  3, 0, 64'h0,                6'd13, 1);
        drain();

        // Backpressure with tag 0x1F.
        rr_mode = 1;
        @(posedge clk); #1 resp_ready = 1'b0;
        issue(1, 64'h40, 3, 0, 64'h0, 6'h1F, 1);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_resp_valid_rise", 80'(resp_valid), 80'd1);
        repeat (5) begin
            @(negedge clk);
            check("bp_req_ready", 80'(req_ready), 80'd0);
            check("bp_resp_rd",   80'(resp_rd),   80'h1F);
        end
        @(posedge clk); #1;
        rr_mode = 2; resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_valid", 80'(resp_valid), 80'd0);
        check("bp_idle_ready", 80'(req_ready),  80'd1);
        drain();

        // Reset during the first BUSY cycle aborts the store.
        issue(0, 64'h80, 3, 0, 64'hAAAA, 6'd20, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("abort");
        reset = 1'b0;
        issue(1, 64'h80, 3, 0, 64'h0, 6'd21, 1);
        drain();

        rr_mode = 0;
        for (int i = 0; i < 300; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 9) < 8) a = a & ~((64'd1 << sz) - 64'd1);
            issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, 6'($urandom_range(0, 63)), 1);
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
